// File: rtl/pulse_pkg.sv
// Definitions shared by the pulse generator and the pulse measurement receiver.
// Both blocks use an asynchronous active-high reset, whatever the board-level polarity.
package pulse_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_MEAS = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    MEAS = ST_MEAS
  } state_t;

endpackage

// File: rtl/pulse_sync.sv
// Multi-flop synchroniser for an asynchronous line, plus a flag that rises once
// every stage holds a sample taken after reset.
module pulse_sync
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic primed
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [SYNC_STAGES-1:0] fill_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      fill_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
      fill_p0 <= {fill_p0[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign q      = sync_p0[SYNC_STAGES-1];
  assign primed = fill_p0[SYNC_STAGES-1];

endmodule

// File: rtl/pulse_measure.sv
// Measures period and high-width of a synchronised pulse train, compares them
// with expected values and declares lock after LOCK_COUNT consecutive matches.
module pulse_measure
  import pulse_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EXP_FREQ    = 10,
  parameter int EXP_WIDTH   = 1,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 pulse_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] width,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 err,
  output logic                 timeout
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] EXP_F   = CNT_WIDTH'(EXP_FREQ);
  localparam logic [CNT_WIDTH-1:0] EXP_W   = CNT_WIDTH'(EXP_WIDTH);
  localparam logic [MC_W-1:0]      LOCK_N  = MC_W'(LOCK_COUNT);
  // A pulse at least as wide as its period cannot exist, so such settings never match.
  localparam bit CAN_MATCH = (EXP_WIDTH < EXP_FREQ);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [MC_W-1:0] sat_lock(input logic [MC_W-1:0] v);
    return (v >= LOCK_N) ? LOCK_N : v + MC_W'(1);
  endfunction

  logic s, s_d, primed, rise, fall, match;
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] per_cnt, per_cnt_nx, wid_cnt, wid_cnt_nx, wid_hold, wid_hold_nx;
  logic [CNT_WIDTH-1:0] period_nx, width_nx;
  logic [MC_W-1:0] match_cnt, match_cnt_nx;
  logic locked_nx, meas_valid_nx, err_nx, timeout_nx;

  pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (pulse_in),
    .q      (s),
    .primed (primed)
  );

  // s_d stays high until the synchroniser holds real samples, so a line that is
  // already high when reset releases is never taken as a rising edge.
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_comb begin
    state_nx      = state;
    per_cnt_nx    = per_cnt;
    wid_cnt_nx    = wid_cnt;
    wid_hold_nx   = wid_hold;
    match_cnt_nx  = match_cnt;
    locked_nx     = locked;
    period_nx     = period;
    width_nx      = width;
    meas_valid_nx = 1'b0;
    err_nx        = 1'b0;
    timeout_nx    = 1'b0;
    match         = CAN_MATCH && (per_cnt == EXP_F) && (wid_hold == EXP_W);
    if (!en) begin
      state_nx     = IDLE;
      per_cnt_nx   = '0;
      wid_cnt_nx   = '0;
      wid_hold_nx  = '0;
      match_cnt_nx = '0;
      locked_nx    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            per_cnt_nx  = CNT_ONE;
            wid_cnt_nx  = CNT_ONE;
            wid_hold_nx = '0;
            state_nx    = MEAS;
          end
        end
        MEAS: begin
          per_cnt_nx = sat_inc(per_cnt);
          if (s)    wid_cnt_nx  = sat_inc(wid_cnt);
          if (fall) wid_hold_nx = wid_cnt;
          // A rise in the same cycle as saturation still completes a normal measurement.
          if (rise) begin
            period_nx     = per_cnt;
            width_nx      = wid_hold;
            meas_valid_nx = 1'b1;
            per_cnt_nx    = CNT_ONE;
            wid_cnt_nx    = CNT_ONE;
            if (match) begin
              match_cnt_nx = sat_lock(match_cnt);
              locked_nx    = (match_cnt_nx == LOCK_N);
            end else begin
              match_cnt_nx = '0;
              locked_nx    = 1'b0;
              err_nx       = 1'b1;
            end
          end else if (&per_cnt) begin
            timeout_nx   = 1'b1;
            locked_nx    = 1'b0;
            match_cnt_nx = '0;
            state_nx     = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d        <= 1'b1;
      state      <= IDLE;
      per_cnt    <= '0;
      wid_cnt    <= '0;
      wid_hold   <= '0;
      match_cnt  <= '0;
      period     <= '0;
      width      <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      s_d        <= primed ? s : 1'b1;
      state      <= state_nx;
      per_cnt    <= per_cnt_nx;
      wid_cnt    <= wid_cnt_nx;
      wid_hold   <= wid_hold_nx;
      match_cnt  <= match_cnt_nx;
      period     <= period_nx;
      width      <= width_nx;
      meas_valid <= meas_valid_nx;
      locked     <= locked_nx;
      err        <= err_nx;
      timeout    <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_pulse_measure.sv
// Bench for pulse_measure: directed scenarios plus random pulse trains, checked by
// a timestamp-based reference model feeding a scoreboard queue.
module tb_pulse_measure;

  localparam int CW     = 8;
  localparam int EXP_P  = 10;
  localparam int EXP_W  = 1;
  localparam int LOCK_N = 4;
  localparam int MAXPER = 255;
  localparam int NH     = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic pulse_in = 1'b0;
  logic [CW-1:0] period, width;
  logic meas_valid, locked, err, timeout;

  pulse_measure #(
    .CNT_WIDTH(CW), .SYNC_STAGES(2), .EXP_FREQ(EXP_P),
    .EXP_WIDTH(EXP_W), .LOCK_COUNT(LOCK_N)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
    .period(period), .width(width), .meas_valid(meas_valid),
    .locked(locked), .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_to;
    int per;
    int wid;
    bit err;
    bit lock;
    int at;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Reference state: line history and timestamps of edges as seen by the receiver.
  bit hist[0:NH-1];
  int m = 0;
  int base = 0;
  bit rst_sel = 1'b1;
  bit en_sel = 1'b1;
  bit armed = 1'b0;
  int t_rise = 0;
  int w_hold = 0;
  int run = 0;
  bit lock_m = 1'b0;
  int last_per = 0;
  int last_wid = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, m);
    end
  endtask

  // The receiver sees the line two cycles late; edges count only once a
  // post-reset sample exists on both sides of the comparison.
  task automatic model_step();
    bit sv, sp, rs, fl, ok;
    int per;
    exp_t e;
    hist[m] = pulse_in;
    if (rst) begin
      armed = 0; run = 0; lock_m = 0; last_per = 0; last_wid = 0;
      base = m + 4;
      sbq.delete();
      return;
    end
    rs = 0; fl = 0;
    if (m >= base) begin
      sv = hist[m-2];
      sp = hist[m-3];
      rs = sv && !sp;
      fl = !sv && sp;
    end
    if (!en) begin
      armed = 0; run = 0; lock_m = 0;
    end else if (!armed) begin
      if (rs) begin armed = 1; t_rise = m; w_hold = 0; end
    end else begin
      if (fl) w_hold = m - t_rise;
      if (rs) begin
        per = m - t_rise;
        ok = (per == EXP_P) && (w_hold == EXP_W);
        if (ok) begin
          if (run < LOCK_N) run++;
          lock_m = (run == LOCK_N);
        end else begin
          run = 0; lock_m = 0;
        end
        e.is_to = 0; e.per = per; e.wid = w_hold; e.err = !ok; e.lock = lock_m; e.at = m;
        sbq.push_back(e);
        last_per = per; last_wid = w_hold; t_rise = m;
      end else if (m - t_rise >= MAXPER) begin
        armed = 0; run = 0; lock_m = 0;
        e.is_to = 1; e.per = last_per; e.wid = last_wid; e.err = 0; e.lock = 0; e.at = m;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic step(input bit p);
    @(posedge clk);
    #1;
    rst = rst_sel;
    en = en_sel;
    pulse_in = p;
    model_step();
    m++;
  endtask

  task automatic gen(input int per, input int w);
    for (int i = 0; i < per; i++) step(i < w);
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_width"}, width, 0);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  // Monitor: entries become due one cycle after the model pushes them.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].at < m - 2) begin
      checks++; errors++;
      $display("FAIL missed_event: got no strobe expected per=%0d timeout=%0b (pushed cycle %0d)",
               sbq[0].per, sbq[0].is_to, sbq[0].at);
      sbq.delete(0);
    end
    if (!rst && (meas_valid || err || timeout)) begin
      if (sbq.size() == 0 || sbq[0].at != m - 2) begin
        checks++; errors++;
        $display("FAIL unexpected_event: got mv=%0b err=%0b to=%0b per=%0d expected no strobe (cycle %0d)",
                 meas_valid, err, timeout, period, m);
      end else begin
        e = sbq.pop_front();
        chk("meas_valid", meas_valid, !e.is_to);
        chk("err", err, e.err);
        chk("timeout", timeout, e.is_to);
        chk("period", period, e.per);
        chk("width", width, e.wid);
        chk("locked", locked, e.lock);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, w;
    // Reset with line low, then a good train: lock at the 4th measurement.
    rst_sel = 1; en_sel = 1;
    repeat (3) step(0);
    check_all_zero("reset");
    rst_sel = 0;
    repeat (8) gen(10, 1);
    @(negedge clk); chk("locked_good_train", locked, 1);

    // One long period breaks lock, four good ones restore it.
    gen(12, 1);
    repeat (5) gen(10, 1);
    @(negedge clk); chk("relocked", locked, 1);

    // Line high through reset: first rise afterwards only arms.
    rst_sel = 1;
    repeat (3) step(1);
    rst_sel = 0;
    repeat (15) step(1);
    @(negedge clk); chk("high_from_reset_locked", locked, 0);
    repeat (5) step(0);
    repeat (6) gen(10, 1);

    // Stuck low after an edge: timeout at saturation.
    gen(10, 1);
    repeat (300) step(0);
    @(negedge clk); chk("timeout_locked", locked, 0);
    chk("timeout_period_hold", period, EXP_P);
    // Period exactly at saturation is a measurement; one longer is a timeout.
    gen(255, 1);
    gen(256, 1);
    repeat (3) gen(10, 1);

    // Enable dropped mid-period.
    repeat (6) gen(10, 1);
    step(1); step(0); step(0);
    en_sel = 0;
    repeat (3) step(0);
    en_sel = 1;
    @(negedge clk); chk("en_drop_locked", locked, 0);
    chk("en_drop_period_hold", period, EXP_P);
    chk("en_drop_width_hold", width, EXP_W);
    repeat (4) step(0);
    repeat (6) gen(10, 1);

    // Reset in the middle of a high pulse.
    repeat (5) gen(10, 1);
    step(1); step(1);
    rst_sel = 1;
    step(1);
    check_all_zero("mid_reset");
    step(1);
    rst_sel = 0;
    step(1); step(1);
    repeat (8) step(0);
    repeat (6) gen(10, 1);

    // Random trains, mostly nominal, with occasional odd periods and enable drops.
    repeat (150) begin
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 20) : EXP_P;
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(1, p - 1) : 1;
      gen(p, w);
      if ($urandom_range(0, 39) == 0) begin
        en_sel = 0;
        repeat ($urandom_range(1, 4)) step(0);
        en_sel = 1;
      end
    end

    en_sel = 1;
    repeat (5) step(0);
    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
